fb_wb_arbiter: RTL and testbench

FB_WB_ARBITER -- requirements
Module: fb_wb_arbiter

---
 rtl/fb_wb_arbiter.sv | 80 ++++++++
 tb/tb_fb_wb_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fb_wb_arbiter.sv
// Round-robin writeback arbiter: two write requesters share one register-file port, with a registered output stage one cycle after acceptance.
// Backpressure: only one ready per cycle, set from the valids and the priority pointer. The loser holds its request until it is granted.
module fb_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [4:0]      req0_waddr,
    input  logic [XLEN-1:0] req0_wdata,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_waddr,
    input  logic [XLEN-1:0] req1_wdata,
    output logic            req1_ready,
    output logic            we,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    output logic            wb_src,
    output logic [15:0]     conflict_cnt
);

    logic            r_ptr;
    logic            r_we;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic            r_src;
    logic [15:0]     r_cnt;

    logic            w_both;
    logic            w_gnt0;
    logic            w_gnt1;
    logic [4:0]      w_sel_addr;
    logic [XLEN-1:0] w_sel_data;

    // r_ptr = 1 means req1 wins the next contended cycle
    always_comb begin
        w_both     = req0_valid & req1_valid;
        w_gnt0     = ~reset & req0_valid & (~req1_valid | ~r_ptr);
        w_gnt1     = ~reset & req1_valid & (~req0_valid | r_ptr);
        w_sel_addr = w_gnt1 ? req1_waddr : req0_waddr;
        w_sel_data = w_gnt1 ? req1_wdata : req0_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_src   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_both) begin
                r_ptr <= w_gnt0;
                if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            if (w_gnt0 | w_gnt1) begin
                // x0 writes are dropped at the enable but still recorded as a transfer
                r_we    <= (w_sel_addr != 5'd0);
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
                r_src   <= w_gnt1;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign req0_ready   = w_gnt0;
    assign req1_ready   = w_gnt1;
    assign we           = r_we;
    assign waddr        = r_waddr;
    assign wdata        = r_wdata;
    assign wb_src       = r_src;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_fb_wb_arbiter.sv
// Directed table-driven bench for fb_wb_arbiter plus a long contention/saturation sequence.
module tb_fb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [4:0]  req0_waddr;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_waddr;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wb_src;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;
    int row    = 0;

    fb_wb_arbiter #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_waddr   (req0_waddr),
        .req0_wdata   (req0_wdata),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_waddr   (req1_waddr),
        .req1_wdata   (req1_wdata),
        .req1_ready   (req1_ready),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .wb_src       (wb_src),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs are those visible just after the inputs of the row are applied:
    // readys for this row's inputs, registered outputs from the previous edge.
    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        src;
        logic [15:0] cnt;
        logic        chk_data;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic rst, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
        input logic r0, input logic r1, input logic e_we, input logic [4:0] wa,
        input logic [31:0] wd, input logic src, input logic [15:0] cnt, input logic chk_data);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.we = e_we; v.wa = wa; v.wd = wd; v.src = src; v.cnt = cnt;
        v.chk_data = chk_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        //              rst v0 a0  d0            v1 a1  d1            r0 r1 we wa  wd            src cnt  chk
        tbl[0]  = mk(1, 1, 3,  32'h11,       1, 7,  32'h22,       0, 0, 0, 0,  32'h0,        0, 0, 1);
        tbl[1]  = mk(0, 1, 3,  32'h11,       1, 7,  32'h22,       1, 0, 0, 0,  32'h0,        0, 0, 1);
        tbl[2]  = mk(0, 1, 3,  32'h11,       1, 7,  32'h22,       0, 1, 1, 3,  32'h11,       0, 1, 1);
        tbl[3]  = mk(0, 1, 3,  32'h11,       1, 7,  32'h22,       1, 0, 1, 7,  32'h22,       1, 2, 1);
        tbl[4]  = mk(0, 1, 3,  32'h11,       1, 7,  32'h22,       0, 1, 1, 3,  32'h11,       0, 3, 1);
        tbl[5]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 1, 7,  32'h22,       1, 4, 1);
        tbl[6]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 7,  32'h22,       1, 4, 1);
        tbl[7]  = mk(0, 1, 5,  32'h1234,     0, 0,  32'h0,        1, 0, 0, 7,  32'h22,       1, 4, 1);
        tbl[8]  = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 1, 5,  32'h1234,     0, 4, 1);
        tbl[9]  = mk(0, 0, 0,  32'h0,        1, 0,  32'hDEADBEEF, 0, 1, 0, 5,  32'h1234,     0, 4, 1);
        tbl[10] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0,  32'h0,        1, 4, 0);
        tbl[11] = mk(1, 1, 9,  32'hA,        1, 9,  32'hB,        0, 0, 0, 0,  32'h0,        1, 4, 0);
        tbl[12] = mk(0, 1, 9,  32'hA,        1, 9,  32'hB,        1, 0, 0, 0,  32'h0,        0, 0, 1);
        tbl[13] = mk(0, 0, 0,  32'h0,        1, 9,  32'hB,        0, 1, 1, 9,  32'hA,        0, 1, 1);
        tbl[14] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 1, 9,  32'hB,        1, 1, 1);
        tbl[15] = mk(1, 1, 4,  32'h55,       0, 0,  32'h0,        0, 0, 0, 9,  32'hB,        1, 1, 1);
        tbl[16] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0, 0,  32'h0,        0, 0, 1);
        tbl[17] = mk(0, 0, 0,  32'h0,        1, 6,  32'h66,       0, 1, 0, 0,  32'h0,        0, 0, 1);

        reset = 1'b1;
        req0_valid = 1'b0; req0_waddr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_waddr = '0; req1_wdata = '0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            row        = i;
            reset      = tbl[i].rst;
            req0_valid = tbl[i].v0;
            req0_waddr = tbl[i].a0;
            req0_wdata = tbl[i].d0;
            req1_valid = tbl[i].v1;
            req1_waddr = tbl[i].a1;
            req1_wdata = tbl[i].d1;
            #1;
            chk("req0_ready", {31'b0, req0_ready}, {31'b0, tbl[i].r0});
            chk("req1_ready", {31'b0, req1_ready}, {31'b0, tbl[i].r1});
            chk("we", {31'b0, we}, {31'b0, tbl[i].we});
            chk("wb_src", {31'b0, wb_src}, {31'b0, tbl[i].src});
            chk("conflict_cnt", {16'b0, conflict_cnt}, {16'b0, tbl[i].cnt});
            if (tbl[i].chk_data) begin
                chk("waddr", {27'b0, waddr}, {27'b0, tbl[i].wa});
                chk("wdata", wdata, tbl[i].wd);
            end
        end

        // Long contention run: strict alternation, one write per cycle, saturating counter.
        begin
            int bad;
            bad = 0;
            row = 100;
            @(negedge clk);
            reset = 1'b1;
            req0_valid = 1'b1; req0_waddr = 5'd3; req0_wdata = 32'h0;
            req1_valid = 1'b1; req1_waddr = 5'd7; req1_wdata = 32'h1;
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 65541; i++) begin
                #1;
                if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) bad++;
                if (i >= 1 && (we !== 1'b1 || wb_src !== (i % 2 == 0))) bad++;
                if (i == 65534) chk("cnt_ffe", {16'b0, conflict_cnt}, 32'hFFFE);
                if (i == 65535) chk("cnt_sat", {16'b0, conflict_cnt}, 32'hFFFF);
                @(negedge clk);
            end
            #1;
            chk("alternation_errs", bad, 0);
            chk("cnt_hold", {16'b0, conflict_cnt}, 32'hFFFF);

            // Reset with both valid: readys drop at once, counter clears on the edge.
            reset = 1'b1;
            #1;
            chk("rst_r0", {31'b0, req0_ready}, 32'h0);
            chk("rst_r1", {31'b0, req1_ready}, 32'h0);
            @(negedge clk);
            #1;
            chk("rst_we", {31'b0, we}, 32'h0);
            chk("rst_cnt", {16'b0, conflict_cnt}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
